// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Each accepted request runs IDLE -> EXEC -> DONE, giving one op per three cycles at most.
module alu_arbiter #(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = 4,
    parameter int MAX_OP   = 4
) (
    input  logic                input_CLK,
    input  logic                input_Reset_n,
    input  logic                input_Req0,
    input  logic                input_Req1,
    input  logic [WIDTH-1:0]    input_A0,
    input  logic [WIDTH-1:0]    input_B0,
    input  logic [WIDTH-1:0]    input_A1,
    input  logic [WIDTH-1:0]    input_B1,
    input  logic [OP_WIDTH-1:0] input_Op0,
    input  logic [OP_WIDTH-1:0] input_Op1,
    output logic                output_Gnt0,
    output logic                output_Gnt1,
    output logic                output_Done0,
    output logic                output_Done1,
    output logic [WIDTH-1:0]    output_Result,
    output logic                output_Zero,
    output logic                output_Negative,
    output logic                output_Error,
    output logic                output_Busy,
    output logic [WIDTH-1:0]    output_ALU_A,
    output logic [WIDTH-1:0]    output_ALU_B,
    output logic [OP_WIDTH-1:0] output_ALU_Op,
    input  logic [WIDTH-1:0]    input_ALU_Result,
    input  logic                input_ALU_Zero,
    input  logic                input_ALU_Negative
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OP_WIDTH-1:0] MAX_OP_L = OP_WIDTH'(MAX_OP);

    logic [1:0]          state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                win_q, win_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0] alu_op_q, alu_op_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                zero_q, zero_d, neg_q, neg_d, error_q, error_d;

    // Requester 1 wins when it is alone, or when both ask and the pointer names it.
    logic                sel1;
    logic [OP_WIDTH-1:0] op_sel;

    assign sel1   = input_Req1 & (~input_Req0 | ptr_q);
    assign op_sel = sel1 ? input_Op1 : input_Op0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        err_d    = err_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (input_Req0 || input_Req1) begin
                    win_d   = sel1;
                    ptr_d   = ~sel1;
                    alu_a_d = sel1 ? input_A1 : input_A0;
                    alu_b_d = sel1 ? input_B1 : input_B0;
                    if (op_sel > MAX_OP_L) begin
                        alu_op_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        alu_op_d = op_sel;
                        err_d    = 1'b0;
                    end
                    gnt0_d  = ~sel1;
                    gnt1_d  = sel1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // An illegal opcode still runs as an add; its outcome is masked here.
                if (err_q) begin
                    result_d = '0;
                    zero_d   = 1'b0;
                    neg_d    = 1'b0;
                    error_d  = 1'b1;
                end else begin
                    result_d = input_ALU_Result;
                    zero_d   = input_ALU_Zero;
                    neg_d    = input_ALU_Negative;
                    error_d  = 1'b0;
                end
                done0_d = ~win_q;
                done1_d = win_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            err_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            err_q    <= err_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            error_q  <= error_d;
        end
    end

    assign output_Gnt0     = gnt0_q;
    assign output_Gnt1     = gnt1_q;
    assign output_Done0    = done0_q;
    assign output_Done1    = done1_q;
    assign output_Result   = result_q;
    assign output_Zero     = zero_q;
    assign output_Negative = neg_q;
    assign output_Error    = error_q;
    assign output_Busy     = (state_q != S_IDLE);
    assign output_ALU_A    = alu_a_q;
    assign output_ALU_B    = alu_b_q;
    assign output_ALU_Op   = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a transaction-level reference model
// and a behavioural ALU closing the loop on the DUT's operand drive.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0, r1;
    logic [15:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic        gnt0, gnt1, done0, done1, zero, neg, err, busy;
    logic [15:0] result, alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        alu_z, alu_n;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .input_CLK(clk), .input_Reset_n(rst_n),
        .input_Req0(r0), .input_Req1(r1),
        .input_A0(a0), .input_B0(b0), .input_A1(a1), .input_B1(b1),
        .input_Op0(op0), .input_Op1(op1),
        .output_Gnt0(gnt0), .output_Gnt1(gnt1),
        .output_Done0(done0), .output_Done1(done1),
        .output_Result(result), .output_Zero(zero), .output_Negative(neg),
        .output_Error(err), .output_Busy(busy),
        .output_ALU_A(alu_a), .output_ALU_B(alu_b), .output_ALU_Op(alu_op),
        .input_ALU_Result(alu_res), .input_ALU_Zero(alu_z), .input_ALU_Negative(alu_n)
    );

    // Arithmetic meaning of each legal opcode, shared by the ALU stand-in and the model.
    function automatic logic [15:0] calc(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
        int unsigned x;
        x = 0;
        case (op)
            4'd0: x = int'(a) + int'(b);
            4'd1: x = int'(a) + 32'h10000 - int'(b);
            4'd2: x = int'(a & b);
            4'd3: x = int'(a | b);
            4'd4: x = int'(a ^ b);
            default: x = int'(a) + int'(b);
        endcase
        return x[15:0];
    endfunction

    always_comb begin
        alu_res = calc(alu_a, alu_b, alu_op);
        alu_z   = (alu_res == 16'h0);
        alu_n   = alu_res[15];
    end

    // Reference model: a transaction occupies three cycles (grant, done, idle).
    int          m_phase;
    bit          m_ptr, m_win, m_perr;
    bit   [15:0] m_pres;
    bit          m_gnt0, m_gnt1, m_done0, m_done1;
    bit   [15:0] m_res, m_a, m_b;
    bit   [3:0]  m_op;
    bit          m_zero, m_neg, m_err;

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_win = 0; m_perr = 0; m_pres = 0;
        m_gnt0 = 0; m_gnt1 = 0; m_done0 = 0; m_done1 = 0;
        m_res = 0; m_a = 0; m_b = 0; m_op = 0; m_zero = 0; m_neg = 0; m_err = 0;
    endtask

    task automatic model_edge();
        logic [15:0] a, b;
        logic [3:0]  op;
        bit          w;
        m_gnt0 = 0; m_gnt1 = 0; m_done0 = 0; m_done1 = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            if (r0 || r1) begin
                w  = (r0 && r1) ? m_ptr : r1;
                m_ptr = !w;
                m_win = w;
                a  = w ? a1 : a0;
                b  = w ? b1 : b0;
                op = w ? op1 : op0;
                m_a = a; m_b = b;
                if (op > 4) begin
                    m_op = 0; m_perr = 1; m_pres = 0;
                end else begin
                    m_op = op; m_perr = 0; m_pres = calc(a, b, op);
                end
                if (w) m_gnt1 = 1; else m_gnt0 = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_res  = m_pres;
            m_err  = m_perr;
            m_zero = !m_perr && (m_pres == 16'h0);
            m_neg  = !m_perr && m_pres[15];
            if (m_win) m_done1 = 1; else m_done0 = 1;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all();
        chk("gnt0",   32'(gnt0),   32'(m_gnt0));
        chk("gnt1",   32'(gnt1),   32'(m_gnt1));
        chk("done0",  32'(done0),  32'(m_done0));
        chk("done1",  32'(done1),  32'(m_done1));
        chk("busy",   32'(busy),   32'(m_phase != 0));
        chk("result", 32'(result), 32'(m_res));
        chk("zero",   32'(zero),   32'(m_zero));
        chk("neg",    32'(neg),    32'(m_neg));
        chk("error",  32'(err),    32'(m_err));
        chk("alu_a",  32'(alu_a),  32'(m_a));
        chk("alu_b",  32'(alu_b),  32'(m_b));
        chk("alu_op", 32'(alu_op), 32'(m_op));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic logic [3:0] rand_op();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(5, 15));
        return 4'($urandom_range(0, 4));
    endfunction

    initial begin
        model_reset();
        rst_n = 1'b0;
        r0 = 1; r1 = 1;
        a0 = 16'h5678; b0 = 16'h1234; op0 = 4'd1;
        a1 = 16'hAAAA; b1 = 16'h5555; op1 = 4'd4;
        #12;
        compare_all();
        #4 rst_n = 1'b1;

        // Both held from reset: alternate 0,1,0,1 every three cycles.
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 2)  chk("t3_res0", 32'(result), 32'h4444);
            if (i == 5)  chk("t3_res1", 32'(result), 32'hFFFF);
            if (i == 7)  chk("t3_gnt0", 32'(gnt0), 32'h1);
            if (i == 10) chk("t3_gnt1", 32'(gnt1), 32'h1);
        end
        r0 = 0; r1 = 0;

        // Requester 0 alone, add.
        a0 = 16'h1234; b0 = 16'h5678; op0 = 4'd0; r0 = 1;
        step(); chk("t1_gnt0", 32'(gnt0), 32'h1); r0 = 0;
        step(); chk("t1_res", 32'(result), 32'h68AC); chk("t1_done0", 32'(done0), 32'h1);
        step();

        // Requester 1: AND then OR.
        a1 = 16'hAAAA; b1 = 16'h5555; op1 = 4'd2; r1 = 1;
        step(); r1 = 0;
        step(); chk("t2_and", 32'(result), 32'h0); chk("t2_z", 32'(zero), 32'h1);
        step();
        op1 = 4'd3; r1 = 1;
        step(); r1 = 0;
        step(); chk("t2_or", 32'(result), 32'hFFFF); chk("t2_n", 32'(neg), 32'h1);
        step();

        // Illegal opcode, then a legal one clears Error.
        a0 = 16'h0101; b0 = 16'h0202; op0 = 4'hF; r0 = 1;
        step(); chk("t4_aluop", 32'(alu_op), 32'h0); r0 = 0;
        step(); chk("t4_err", 32'(err), 32'h1); chk("t4_res", 32'(result), 32'h0);
        step();
        op0 = 4'd0; r0 = 1;
        step(); r0 = 0;
        step(); chk("t4_clr", 32'(err), 32'h0); chk("t4_res2", 32'(result), 32'h0303);
        step();

        // Operands change after the grant edge; result uses sampled ones.
        a0 = 16'h0001; b0 = 16'h0002; op0 = 4'd0; r0 = 1;
        step();
        r0 = 0; a0 = 16'h0100; b0 = 16'h0200; op0 = 4'd1;
        step(); chk("t6_res", 32'(result), 32'h0003);
        step();

        // Reset in the EXEC cycle of a requester-1 op.
        a1 = 16'hAAAA; b1 = 16'h5555; op1 = 4'd4; r1 = 1;
        step(); chk("t5_gnt1", 32'(gnt1), 32'h1);
        #3 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        r0 = 1; r1 = 1; a0 = 16'h5678; b0 = 16'h1234; op0 = 4'd1;
        step(); chk("t5_nodone", 32'(done1), 32'h0);
        #4 rst_n = 1'b1;
        step(); chk("t5_first0", 32'(gnt0), 32'h1);
        r0 = 0; r1 = 0;
        step(); step();

        // Randomized traffic; a granted requester either drops or keeps asking.
        for (int i = 0; i < 600; i++) begin
            step();
            if (m_gnt0 && $urandom_range(0, 1) == 1) r0 = 0;
            if (m_gnt1 && $urandom_range(0, 1) == 1) r1 = 0;
            if (!r0) begin
                a0 = 16'($urandom); b0 = 16'($urandom); op0 = rand_op();
                if ($urandom_range(0, 2) == 0) r0 = 1;
            end
            if (!r1) begin
                a1 = 16'($urandom); b1 = 16'($urandom); op1 = rand_op();
                if ($urandom_range(0, 2) == 0) r1 = 1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
